pi_controller_mc: RTL

Time-multiplexed, parametrised PI controller serving CH independent loops from one 5-stage pipeline, one sample per clock. It sits between the FOC Park-transform outputs (Id/Iq, speed or position errors) and the inverse-Park/SVPWM stage. It holds a per-channel saturating integrator and applies a per-sample output clamp with conditional-integration anti-windup. It also supports a per-channel integrator clear.

---
 rtl/pi_mc_pkg.sv | 37 +++
 rtl/pi_integ_bank.sv | 55 +++++
 rtl/pi_controller_mc.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pi_mc_pkg.sv
// Shared helpers for pi_controller_mc: symmetric saturating add/multiply and output clamp.
// Arithmetic is done at a wide width and saturated to a caller-given accumulator width.
package pi_mc_pkg;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned MW     = 128;

  typedef logic signed [MW-1:0] wide_t;

  // Largest positive code of an aw-bit signed value; the range is kept symmetric around it.
  function automatic wide_t sat_max(input int unsigned aw);
    return (wide_t'(1) <<< (aw - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat(input wide_t x, input int unsigned aw);
    wide_t mx;
    mx = sat_max(aw);
    if (x > mx) return mx;
    if (x < -mx) return -mx;
    return x;
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned aw);
    return sat(a + b, aw);
  endfunction

  function automatic wide_t sat_mul(input wide_t a, input wide_t b, input int unsigned aw);
    return sat(a * b, aw);
  endfunction

  function automatic wide_t clamp(input wide_t v, input wide_t lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/pi_integ_bank.sv
// Per-channel integrator and anti-windup flag storage.
// Combinational read port; synchronous integrator write and independent flag write.
module pi_integ_bank
  import pi_mc_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned CH = 4,
  parameter int unsigned CW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CW-1:0]        rd_ch_i,
  output logic signed [AW-1:0] rd_integ_o,
  output logic                 rd_hi_o,
  output logic                 rd_lo_o,
  input  logic                 integ_we_i,
  input  logic [CW-1:0]        integ_ch_i,
  input  logic signed [AW-1:0] integ_val_i,
  input  logic                 integ_clr_i,
  input  logic                 flag_we_i,
  input  logic [CW-1:0]        flag_ch_i,
  input  logic                 flag_hi_i,
  input  logic                 flag_lo_i
);

  logic signed [AW-1:0] integ_q [CH];
  logic [CH-1:0]        hi_q;
  logic [CH-1:0]        lo_q;

  assign rd_integ_o = integ_q[rd_ch_i];
  assign rd_hi_o    = hi_q[rd_ch_i];
  assign rd_lo_o    = lo_q[rd_ch_i];

  // A clear landing on the same edge as a flag update wins, since it belongs to the newer sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) integ_q[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (flag_we_i) begin
        hi_q[flag_ch_i] <= flag_hi_i;
        lo_q[flag_ch_i] <= flag_lo_i;
      end
      if (integ_we_i) begin
        integ_q[integ_ch_i] <= integ_val_i;
        if (integ_clr_i) begin
          hi_q[integ_ch_i] <= 1'b0;
          lo_q[integ_ch_i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pi_controller_mc.sv
// Time-multiplexed PI controller: CH loops share one 5-stage pipeline, one sample per clock,
// with saturating integrators, output clamp and conditional-integration anti-windup.
module pi_controller_mc
  import pi_mc_pkg::*;
#(
  parameter int unsigned DW   = 16,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned GW   = 31,
  parameter int unsigned FRAC = 16,
  parameter int unsigned CH   = 4,
  localparam int unsigned CW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [CW-1:0]        i_ch,
  input  logic signed [DW-1:0] i_aim,
  input  logic signed [DW-1:0] i_real,
  input  logic [GW-1:0]        i_Kp,
  input  logic [GW-1:0]        i_Ki,
  input  logic [DW-2:0]        i_lim,
  input  logic                 i_clr,
  output logic                 o_en,
  output logic [CW-1:0]        o_ch,
  output logic signed [DW-1:0] o_value,
  output logic                 o_sat
);

  localparam int unsigned EW = DW + 1;
  localparam int unsigned VW = AW - FRAC;

  logic                 v1_q, v2_q, v3_q, v4_q;
  logic [CW-1:0]        ch1_q, ch2_q, ch3_q, ch4_q;
  logic signed [EW-1:0] err1_q;
  logic [GW-1:0]        kp1_q, ki1_q, ki2_q;
  logic [DW-2:0]        lim1_q, lim2_q, lim3_q, lim4_q;
  logic                 clr1_q;
  logic signed [AW-1:0] kp_t2_q, integ2_q, kp_t3_q, ki_t3_q, sum4_q;
  logic                 o_en_q, o_sat_q;
  logic [CW-1:0]        o_ch_q;
  logic signed [DW-1:0] o_value_q;

  logic                 ch_ok;
  logic signed [AW-1:0] rd_integ, integ_d, kp_t_d, ki_t_d, sum_d;
  logic                 rd_hi, rd_lo, err_pos, err_neg, hold;
  logic signed [VW-1:0] v_d;
  wide_t                vw, limw;
  logic signed [DW-1:0] value_d;
  logic                 sat_hi_d, sat_lo_d;

  assign ch_ok = (32'(i_ch) < CH);

  pi_integ_bank #(.AW(AW), .CH(CH), .CW(CW)) u_bank (
    .clk         (clk),
    .rst         (rst),
    .rd_ch_i     (ch1_q),
    .rd_integ_o  (rd_integ),
    .rd_hi_o     (rd_hi),
    .rd_lo_o     (rd_lo),
    .integ_we_i  (v1_q),
    .integ_ch_i  (ch1_q),
    .integ_val_i (integ_d),
    .integ_clr_i (clr1_q),
    .flag_we_i   (v4_q),
    .flag_ch_i   (ch4_q),
    .flag_hi_i   (sat_hi_d),
    .flag_lo_i   (sat_lo_d)
  );

  // S2: P term and integrator update; the write-back lets a back-to-back sample see the new value.
  always_comb begin
    err_pos = !err1_q[EW-1] && (err1_q != '0);
    err_neg = err1_q[EW-1];
    hold    = (rd_hi && err_pos) || (rd_lo && err_neg);
    integ_d = AW'(sat_add(wide_t'(rd_integ), wide_t'(err1_q), AW));
    if (clr1_q) integ_d = '0;
    else if (hold) integ_d = rd_integ;
    kp_t_d  = AW'(sat_mul(wide_t'(err1_q), wide_t'(kp1_q), AW));
  end

  assign ki_t_d = AW'(sat_mul(wide_t'(integ2_q), wide_t'(ki2_q), AW));
  assign sum_d  = AW'(sat_add(wide_t'(kp_t3_q), wide_t'(ki_t3_q), AW));

  // S5: floor-scale to output units, clamp, and report which side saturated.
  always_comb begin
    v_d      = VW'(sum4_q >>> FRAC);
    vw       = wide_t'(v_d);
    limw     = wide_t'(lim4_q);
    sat_hi_d = (vw > limw);
    sat_lo_d = (vw < -limw);
    value_d  = DW'(clamp(vw, limw));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0; ch1_q <= '0; err1_q <= '0; kp1_q <= '0; ki1_q <= '0; lim1_q <= '0; clr1_q <= 1'b0;
      v2_q <= 1'b0; ch2_q <= '0; kp_t2_q <= '0; integ2_q <= '0; ki2_q <= '0; lim2_q <= '0;
      v3_q <= 1'b0; ch3_q <= '0; kp_t3_q <= '0; ki_t3_q <= '0; lim3_q <= '0;
      v4_q <= 1'b0; ch4_q <= '0; sum4_q <= '0; lim4_q <= '0;
    end else begin
      v1_q   <= i_en && ch_ok;
      ch1_q  <= i_ch;
      err1_q <= EW'(i_aim) - EW'(i_real);
      kp1_q  <= i_Kp;
      ki1_q  <= i_Ki;
      lim1_q <= i_lim;
      clr1_q <= i_clr;

      v2_q     <= v1_q;
      ch2_q    <= ch1_q;
      kp_t2_q  <= kp_t_d;
      integ2_q <= integ_d;
      ki2_q    <= ki1_q;
      lim2_q   <= lim1_q;

      v3_q    <= v2_q;
      ch3_q   <= ch2_q;
      kp_t3_q <= kp_t2_q;
      ki_t3_q <= ki_t_d;
      lim3_q  <= lim2_q;

      v4_q   <= v3_q;
      ch4_q  <= ch3_q;
      sum4_q <= sum_d;
      lim4_q <= lim3_q;
    end
  end

  // Output fields hold their last value between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_en_q    <= 1'b0;
      o_ch_q    <= '0;
      o_value_q <= '0;
      o_sat_q   <= 1'b0;
    end else begin
      o_en_q <= v4_q;
      if (v4_q) begin
        o_ch_q    <= ch4_q;
        o_value_q <= value_d;
        o_sat_q   <= sat_hi_d || sat_lo_d;
      end
    end
  end

  assign o_en    = o_en_q;
  assign o_ch    = o_ch_q;
  assign o_value = o_value_q;
  assign o_sat   = o_sat_q;

endmodule
